voxel_fetch_master: RTL and testbench

// - Avalon-MM pipelined read initiator for the GPU m1 master port: fetches word_count 32-bit words from base_addr
//   (voxel or palette buffer in SDRAM) and presents them in order on a valid/ready stream to the render pipeline.
// - Keeps up to MAX_OUTSTANDING reads in flight. Space for every issued read is reserved in an internal FIFO,
//   so read data is never dropped and the interconnect is never back-pressured.

---
 rtl/voxel_fetch_master_if.sv | 28 ++
 rtl/voxel_fetch_master.sv | 147 ++++++++++++++
 tb/tb_voxel_fetch_master.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voxel_fetch_master_if.sv
// Voxel fetch bus bundle: Avalon-MM read port
// and the valid/ready output word stream.
interface voxel_fetch_master_if;
  logic [31:0] m1_address;
  logic        m1_read;
  logic        m1_waitrequest;
  logic [31:0] m1_readdata;
  logic        m1_readdatavalid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output m1_address, m1_read,
    input  m1_waitrequest, m1_readdata,
    input  m1_readdatavalid,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    input  m1_address, m1_read,
    output m1_waitrequest, m1_readdata,
    output m1_readdatavalid,
    input  out_data, out_valid,
    output out_ready
  );
endinterface

// File: rtl/voxel_fetch_master.sv
// Voxel fetch master: pipelined Avalon reads into
// a space-reserved FIFO, streamed out in order.
module voxel_fetch_master #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] word_count,
  output logic        busy,
  output logic        done,
  voxel_fetch_master_if.master bus
);

  localparam int AW =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] L_DEPTH =
    FIFO_DEPTH[CW:0];
  localparam logic [CW-1:0] L_MAX =
    MAX_OUTSTANDING[CW-1:0];
  localparam logic [AW-1:0] L_LAST =
    AW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t        r_state;
  logic [31:0]   r_addr;
  logic [31:0]   r_remaining;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic          r_read;
  logic          r_busy;
  logic          r_done;

  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_out_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW:0]   w_reserved;
  logic          w_credit;

  // Handshake events and next-cycle credit view.
  // A stale response (nothing in flight) is dropped.
  always_comb begin
    w_accept   = r_read && !bus.m1_waitrequest;
    w_push     = bus.m1_readdatavalid
                 && (r_out != '0);
    w_pop      = (r_cnt != '0) && bus.out_ready;
    w_out_nxt  = r_out + CW'(w_accept)
                 - CW'(w_push);
    w_cnt_nxt  = r_cnt + CW'(w_push)
                 - CW'(w_pop);
    w_reserved = {1'b0, w_out_nxt}
                 + {1'b0, w_cnt_nxt};
    w_credit   = (w_reserved < L_DEPTH)
                 && (w_out_nxt < L_MAX);
  end

  // Control FSM, counters and FIFO pointers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_out       <= '0;
      r_cnt       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_read      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_out  <= w_out_nxt;
      r_cnt  <= w_cnt_nxt;
      if (w_push)
        r_wptr <= (r_wptr == L_LAST) ?
                  '0 : r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= (r_rptr == L_LAST) ?
                  '0 : r_rptr + 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              r_done <= 1'b1;
            end else begin
              r_addr      <= base_addr & ~32'h3;
              r_remaining <= word_count;
              r_busy      <= 1'b1;
              r_read      <= w_credit;
              r_state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_addr      <= r_addr + 32'd4;
            r_remaining <= r_remaining - 32'd1;
            if (r_remaining == 32'd1) begin
              r_read  <= 1'b0;
              r_state <= S_DRAIN;
            end else begin
              r_read <= w_credit;
            end
          end else if (!r_read) begin
            r_read <= w_credit;
          end
        end
        S_DRAIN: begin
          if (r_out == '0 && r_cnt == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; contents are don't-care when empty.
  always_ff @(posedge clock) begin
    if (w_push)
      r_mem[r_wptr] <= bus.m1_readdata;
  end

  assign bus.m1_address = r_addr;
  assign bus.m1_read    = r_read;
  assign bus.out_valid  = (r_cnt != '0);
  assign bus.out_data   = (r_cnt != '0) ?
                          r_mem[r_rptr] : '0;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_voxel_fetch_master.sv
// Bench for voxel_fetch_master: Avalon slave model,
// stream consumer and in-order reference queues.
module tb_voxel_fetch_master;

  localparam int MAXO  = 8;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [31:0] cnt = '0;
  logic        busy;
  logic        done;

  voxel_fetch_master_if bus();

  voxel_fetch_master #(
    .MAX_OUTSTANDING(MAXO),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clk),
    .reset_n(rst_n),
    .start(start),
    .base_addr(base),
    .word_count(cnt),
    .busy(busy),
    .done(done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int lat = 2;
  int wr_mode = 0;
  int rdy_mode = 0;
  int hold_at = 0;
  int stall_left = 0;
  int acc_idx = 0;
  int pop_idx = 0;
  int done_cnt = 0;
  int acc_total = 0;
  int ret_total = 0;
  int pop_total = 0;
  int read_seen = 0;
  int late_ret = 0;
  bit track = 1'b1;
  bit post_reset = 1'b0;
  bit done_seen = 1'b0;
  bit prev_stall = 1'b0;
  bit chk_ov = 1'b0;
  bit wr;
  bit rdy;
  logic [31:0] prev_addr = '0;
  logic [31:0] seed = '0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          pend_due[$];
  logic [31:0] pend_addr[$];

  function automatic logic [31:0] mdata(
    input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Slave, consumer and scoreboard, all sampled
  // mid-cycle; driven inputs act on the next edge.
  always @(negedge clk) begin
    cyc++;
    wr = 1'b0;
    case (wr_mode)
      1: wr = ($urandom_range(0, 2) == 0);
      2: if (bus.m1_read && acc_idx == 1
             && stall_left > 0) begin
           wr = 1'b1;
           stall_left--;
         end
      3: wr = (acc_idx >= hold_at);
      default: wr = 1'b0;
    endcase
    bus.m1_waitrequest = wr;

    if (prev_stall && rst_n) begin
      chk("stall_read", 32'(bus.m1_read), 32'd1);
      chk("stall_addr", bus.m1_address, prev_addr);
    end
    prev_stall = rst_n && bus.m1_read && wr;
    prev_addr  = bus.m1_address;

    if (chk_ov) begin
      chk("rdv_to_valid", 32'(bus.out_valid), 32'd1);
      chk_ov = 1'b0;
    end

    if (rst_n && bus.m1_read) read_seen++;
    if (rst_n && bus.m1_read && !wr) begin
      if (acc_idx < exp_addr.size())
        chk("rd_addr", bus.m1_address,
            exp_addr[acc_idx]);
      else
        chk("extra_read", acc_idx, exp_addr.size());
      acc_idx++;
      acc_total++;
      pend_due.push_back(cyc + lat);
      pend_addr.push_back(bus.m1_address);
      if (track) begin
        chk("max_outstanding",
            32'(acc_total - ret_total > MAXO), 32'd0);
        chk("fifo_reserve",
            32'(acc_total - pop_total > DEPTH), 32'd0);
      end
    end

    if (pend_due.size() > 0 && pend_due[0] <= cyc)
    begin
      bus.m1_readdatavalid = 1'b1;
      bus.m1_readdata = mdata(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
      ret_total++;
      if (!track) late_ret++;
      if (track && rst_n && !bus.out_valid)
        chk_ov = 1'b1;
    end else begin
      bus.m1_readdatavalid = 1'b0;
      bus.m1_readdata = $urandom;
    end

    case (rdy_mode)
      1: rdy = ($urandom_range(0, 1) == 1);
      2: rdy = 1'b0;
      default: rdy = 1'b1;
    endcase
    bus.out_ready = rdy;

    if (rst_n && bus.out_valid && rdy) begin
      if (pop_idx < exp_data.size())
        chk("out_data", bus.out_data,
            exp_data[pop_idx]);
      else
        chk("extra_word", pop_idx, exp_data.size());
      pop_idx++;
      pop_total++;
    end

    if (rst_n && done) begin
      done_cnt++;
      done_seen = 1'b1;
    end

    if (post_reset) begin
      chk("post_rst_valid", 32'(bus.out_valid), 0);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_read", 32'(bus.m1_read), 0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
  end

  task automatic txn_begin(input logic [31:0] b,
                           input logic [31:0] c);
    logic [31:0] a;
    seed = $urandom;
    exp_addr.delete();
    exp_data.delete();
    a = {b[31:2], 2'b00};
    for (int i = 0; i < int'(c); i++) begin
      exp_addr.push_back(a);
      exp_data.push_back(mdata(a));
      a = a + 32'd4;
    end
    acc_idx = 0;
    pop_idx = 0;
    done_cnt = 0;
    done_seen = 1'b0;
    stall_left = 3;
    @(negedge clk);
    base = b;
    cnt = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = $urandom;
    cnt = $urandom;
    if (c != 0) begin
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("first_read", 32'(bus.m1_read), 32'd1);
    end
  endtask

  task automatic txn_wait(input int c,
                          input int limit);
    int n = 0;
    while (!done_seen && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done_seen), 32'd1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt, 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("reads_issued", acc_idx, c);
    chk("words_out", pop_idx, c);
    chk("empty_after", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: run did not end");
    $fatal(1, "timeout");
  end

  initial begin
    int r0;
    int n;
    bus.m1_waitrequest = 1'b0;
    bus.m1_readdata = '0;
    bus.m1_readdatavalid = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_read", 32'(bus.m1_read), 32'd0);
    chk("rst_addr", bus.m1_address, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    lat = 2; wr_mode = 0; rdy_mode = 0;
    txn_begin(32'h1000_0003, 32'd4);
    txn_wait(4, 100);

    seed = $urandom;
    exp_addr.delete();
    exp_data.delete();
    done_cnt = 0;
    @(negedge clk);
    base = 32'h4000_0000;
    cnt = 32'd0;
    start = 1'b1;
    r0 = read_seen;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("zero_done_len", 32'(done), 32'd0);
    repeat (8) @(negedge clk);
    chk("zero_no_read", read_seen, r0);
    chk("zero_done_once", done_cnt, 32'd1);

    rdy_mode = 2;
    txn_begin(32'h0800_0040, 32'd40);
    repeat (60) @(negedge clk);
    chk("hold_reads", acc_idx, 32'd16);
    chk("hold_read_low", 32'(bus.m1_read), 32'd0);
    chk("hold_valid", 32'(bus.out_valid), 32'd1);
    chk("hold_busy", 32'(busy), 32'd1);
    rdy_mode = 0;
    txn_wait(40, 400);

    wr_mode = 2;
    txn_begin(32'h3000_0100, 32'd6);
    txn_wait(6, 100);
    chk("stall_used", stall_left, 32'd0);

    wr_mode = 0;
    txn_begin(32'hFFFF_FFF8, 32'd4);
    txn_wait(4, 100);

    for (int t = 0; t < 4; t++) begin
      int c;
      c = $urandom_range(1, 30);
      lat = $urandom_range(1, 6);
      wr_mode = 1;
      rdy_mode = 1;
      txn_begin($urandom, c);
      txn_wait(c, 1000);
    end

    lat = 12; wr_mode = 3; hold_at = 5;
    rdy_mode = 0;
    late_ret = 0;
    txn_begin(32'h2000_0000, 32'd20);
    n = 0;
    while (acc_idx < 5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_reads", acc_idx, 32'd5);
    repeat (2) @(negedge clk);
    track = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_read", 32'(bus.m1_read), 32'd0);
    chk("mid_rst_addr", bus.m1_address, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    rst_n = 1'b1;
    wr_mode = 0;
    post_reset = 1'b1;
    repeat (25) @(negedge clk);
    chk("late_returns", late_ret, 32'd5);
    chk("no_done_rst", done_cnt, 32'd0);
    post_reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
